// File: rtl/conv11_feature_sender_if.sv
// Bus bundle between the feature sender, its feature-map RAM and the conv11 input stage.
// The master side issues RAM reads and drives the pixel stream; the slave side is RAM plus receiver.
interface conv11_feature_sender_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  input_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_last;
  logic                  input_ready;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    output input_valid,
    output data_out,
    output data_last,
    input  input_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    input  input_valid,
    input  data_out,
    input  data_last,
    output input_ready
  );
endinterface

// File: rtl/conv11_feature_sender.sv
// Streams one feature map from a synchronous RAM to the conv11 input stage, one pixel per
// valid/ready transfer, using a 2-entry prefetch FIFO with credit-based read issue.
module conv11_feature_sender #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int CH         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  conv11_feature_sender_if.master bus
);

  localparam int TOTAL = IMG_W * IMG_H * CH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      send_cnt;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic [2:0]            credits_used;

  // Credits count buffered words plus the read still in the RAM pipeline; a pop in the
  // same cycle frees one, which keeps the stream bubble-free with ready held high.
  always_comb begin
    pop          = bus.input_valid && bus.input_ready;
    push         = inflight;
    credits_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    rd_issue     = (state == RUN) && (issue_cnt < TOTAL_C) && (credits_used < 3'd2);
  end

  assign bus.mem_rd_en   = rd_issue;
  assign bus.mem_addr    = base_q + ADDR_WIDTH'(issue_cnt);
  assign bus.input_valid = (fifo_count != 2'd0);
  assign bus.data_out    = bus.input_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.data_last   = bus.input_valid && (send_cnt == LAST_C);
  assign busy            = (state != IDLE);
  assign done            = (state == FIN);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      issue_cnt  <= '0;
      send_cnt   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight   <= rd_issue;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (rd_issue) issue_cnt <= issue_cnt + CNT_ONE;
      if (pop)      send_cnt  <= send_cnt + CNT_ONE;

      unique case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            issue_cnt <= '0;
            send_cnt  <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          // Leave on the final transfer so done follows the last pixel by one cycle.
          if (pop && (send_cnt == LAST_C)) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; data_out is masked while the FIFO is
  // empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rd_data;
  end

endmodule

// File: tb/tb_conv11_feature_sender.sv
// Directed bench for conv11_feature_sender: three instances (2x2x1, 8x8x2, 1x1x1) share one
// behavioural RAM; expected pixels come from that RAM image and hand-written tables.
module tb_conv11_feature_sender;

  logic clk;
  logic rst;
  logic start_a, start_b, start_c;
  logic [11:0] base_a, base_b, base_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ram [4096];

  conv11_feature_sender_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) ia ();
  conv11_feature_sender_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) ib ();
  conv11_feature_sender_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) ic ();

  conv11_feature_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .IMG_W(2), .IMG_H(2), .CH(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .bus(ia)
  );
  conv11_feature_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .IMG_W(8), .IMG_H(8), .CH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .bus(ib)
  );
  conv11_feature_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .IMG_W(1), .IMG_H(1), .CH(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .base_addr(base_c),
    .busy(busy_c), .done(done_c), .bus(ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: data appears one cycle after the read strobe.
  always @(posedge clk) if (ia.mem_rd_en) ia.mem_rd_data <= ram[ia.mem_addr];
  always @(posedge clk) if (ib.mem_rd_en) ib.mem_rd_data <= ram[ib.mem_addr];
  always @(posedge clk) if (ic.mem_rd_en) ic.mem_rd_data <= ram[ic.mem_addr];

  // Cycle-by-cycle expectations for the 2x2 frame at 0x010, ready held high, cycles start+1..start+8.
  bit         exp_rd    [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit         exp_valid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  bit         exp_last  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  bit         exp_done  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  bit         exp_busy  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] exp_px    [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  // 1x1x1 frame expectations, cycles start+1..start+5.
  bit c_rd    [5] = '{1, 0, 0, 0, 0};
  bit c_valid [5] = '{0, 0, 1, 0, 0};
  bit c_done  [5] = '{0, 0, 0, 1, 0};
  bit c_busy  [5] = '{1, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"},  32'(busy_a),         32'd0);
    check({tag, "_done"},  32'(done_a),         32'd0);
    check({tag, "_rd_en"}, 32'(ia.mem_rd_en),   32'd0);
    check({tag, "_addr"},  32'(ia.mem_addr),    32'd0);
    check({tag, "_valid"}, 32'(ia.input_valid), 32'd0);
    check({tag, "_data"},  32'(ia.data_out),    32'd0);
    check({tag, "_last"},  32'(ia.data_last),   32'd0);
  endtask

  task automatic pulse_start_a(input logic [11:0] base);
    @(negedge clk);
    start_a = 1'b1;
    base_a  = base;
    #1;
  endtask

  // Runs the 4-pixel instance with ready high until done, checking every read address and
  // every transferred pixel against the RAM image. A start pulse is injected at cycle 'poke'.
  task automatic run_a(input logic [11:0] base, input int sent0, input int iss0, input int poke,
                       output int sent, output int iss, output bit dn);
    sent = sent0;
    iss  = iss0;
    dn   = 1'b0;
    for (int c = 0; c < 100 && !dn; c++) begin
      @(negedge clk);
      start_a = (c == poke);
      if (c == poke) base_a = 12'h100;
      ia.input_ready = 1'b1;
      #1;
      if (ia.mem_rd_en) begin
        check("a_rd_addr", 32'(ia.mem_addr), 32'(12'(base + 12'(iss))));
        iss++;
      end
      if (ia.input_valid) begin
        check("a_data", 32'(ia.data_out), 32'(ram[12'(base + 12'(sent))]));
        check("a_last", 32'(ia.data_last), 32'(sent == 3));
        sent++;
      end
      if (done_a) dn = 1'b1;
    end
  endtask

  initial begin
    int  sent, iss, n_rd, n_tx, n_done;
    bit  dn;

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
    ram[12'h010] = 8'hA1; ram[12'h011] = 8'hB2; ram[12'h012] = 8'hC3; ram[12'h013] = 8'hD4;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;
    ram[12'h030] = 8'h5C;

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    base_a = '0; base_b = '0; base_c = '0;
    ia.input_ready = 1'b0; ib.input_ready = 1'b0; ic.input_ready = 1'b0;

    // Reset for 3 cycles, then 10 idle cycles with no start.
    repeat (3) @(negedge clk);
    #1;
    check_zero_a("reset");
    rst = 1'b0;
    n_rd = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (ia.mem_rd_en || ib.mem_rd_en || ic.mem_rd_en) n_rd++;
    end
    check("idle_no_reads", 32'(n_rd), 32'd0);

    // Streaming with ready always high: latency, back-to-back transfers, last, done.
    ia.input_ready = 1'b1;
    pulse_start_a(12'h010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      check("stream_rd_en", 32'(ia.mem_rd_en), 32'(exp_rd[i]));
      if (exp_rd[i]) check("stream_addr", 32'(ia.mem_addr), 32'(12'h010 + i));
      check("stream_valid", 32'(ia.input_valid), 32'(exp_valid[i]));
      if (exp_valid[i]) check("stream_data", 32'(ia.data_out), 32'(exp_px[i-2]));
      check("stream_last", 32'(ia.data_last), 32'(exp_last[i]));
      check("stream_done", 32'(done_a), 32'(exp_done[i]));
      check("stream_busy", 32'(busy_a), 32'(exp_busy[i]));
    end

    // Backpressure: ready low through the first 5 valid cycles.
    ia.input_ready = 1'b0;
    pulse_start_a(12'h010);
    n_rd = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      if (ia.mem_rd_en) n_rd++;
      if (i >= 2) begin
        check("bp_valid_held", 32'(ia.input_valid), 32'd1);
        check("bp_data_held",  32'(ia.data_out),    32'hA1);
        check("bp_last_low",   32'(ia.data_last),   32'd0);
        check("bp_no_read",    32'(ia.mem_rd_en),   32'd0);
      end
    end
    check("bp_reads_before_release", 32'(n_rd), 32'd2);
    run_a(12'h010, 0, 2, -1, sent, iss, dn);
    check("bp_transfers", 32'(sent), 32'd4);
    check("bp_reads",     32'(iss),  32'd4);
    check("bp_done",      32'(dn),   32'd1);

    // Start while busy is ignored; start in the cycle after done begins a new frame.
    pulse_start_a(12'h010);
    run_a(12'h010, 0, 0, 2, sent, iss, dn);
    check("sb_transfers", 32'(sent), 32'd4);
    check("sb_reads",     32'(iss),  32'd4);
    check("sb_done",      32'(dn),   32'd1);
    pulse_start_a(12'h014);
    check("sb_idle_after_done", 32'(busy_a), 32'd0);
    run_a(12'h014, 0, 0, -1, sent, iss, dn);
    check("b2b_transfers", 32'(sent), 32'd4);
    check("b2b_done",      32'(dn),   32'd1);

    // Mid-frame reset after 3 transfers: outputs clear, no done, restart from pixel 0.
    pulse_start_a(12'h010);
    n_tx = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      ia.input_ready = 1'b1;
      #1;
      if (ia.input_valid && ia.input_ready) n_tx++;
    end
    check("mr_transfers_before_reset", 32'(n_tx), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    ia.input_ready = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_a("mid_reset");
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done_a || ia.input_valid) n_done++;
    end
    check("mr_no_done_no_data", 32'(n_done), 32'd0);
    pulse_start_a(12'h010);
    run_a(12'h010, 0, 0, -1, sent, iss, dn);
    check("mr_restart_transfers", 32'(sent), 32'd4);
    check("mr_restart_done",      32'(dn),   32'd1);

    // Address wrap: 0xFFE, 0xFFF, 0x000, 0x001.
    pulse_start_a(12'hFFE);
    run_a(12'hFFE, 0, 0, -1, sent, iss, dn);
    check("wrap_transfers", 32'(sent), 32'd4);
    check("wrap_reads",     32'(iss),  32'd4);
    check("wrap_done",      32'(dn),   32'd1);

    // Single-pixel frame.
    ic.input_ready = 1'b1;
    @(negedge clk);
    start_c = 1'b1;
    base_c  = 12'h030;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_c = 1'b0;
      #1;
      check("one_rd_en", 32'(ic.mem_rd_en), 32'(c_rd[i]));
      if (c_rd[i]) check("one_addr", 32'(ic.mem_addr), 32'h030);
      check("one_valid", 32'(ic.input_valid), 32'(c_valid[i]));
      if (c_valid[i]) begin
        check("one_data", 32'(ic.data_out),  32'h5C);
        check("one_last", 32'(ic.data_last), 32'd1);
      end
      check("one_done", 32'(done_c), 32'(c_done[i]));
      check("one_busy", 32'(busy_c), 32'(c_busy[i]));
    end

    // 8x8x2 frame with 30%-duty random ready.
    @(negedge clk);
    start_b = 1'b1;
    base_b  = 12'h200;
    #1;
    sent = 0;
    iss  = 0;
    dn   = 1'b0;
    for (int c = 0; c < 3000 && !dn; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      ib.input_ready = ($urandom_range(0, 99) < 30);
      #1;
      if (ib.mem_rd_en) begin
        check("rand_rd_addr", 32'(ib.mem_addr), 32'(12'h200 + iss));
        iss++;
      end
      if (ib.input_valid && ib.input_ready) begin
        check("rand_data", 32'(ib.data_out),  32'(ram[12'(12'h200 + sent)]));
        check("rand_last", 32'(ib.data_last), 32'(sent == 127));
        sent++;
      end
      if (done_b) dn = 1'b1;
    end
    check("rand_transfers", 32'(sent), 32'd128);
    check("rand_reads",     32'(iss),  32'd128);
    check("rand_done",      32'(dn),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv11_feature_sender.md
Name: conv11_feature_sender

Overview:
- Feeds the 1x1 convolution input stage with one feature map, one pixel per transfer.
- Reads the map from a synchronous on-chip RAM at base_addr, one word per address, in raster order: channel-major, then row, then column.
- Drives the valid/ready handshake that the conv11 input buffer receives.
- Sits between the feature-map BRAM and the conv11 input block.

Parameters:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 12, RAM address width.
- IMG_W, 8, map width in pixels.
- IMG_H, 8, map height in pixels.
- CH, 1, channel count.
- TOTAL = IMG_W*IMG_H*CH is derived. It must be ≥1 and ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send one frame.
- base_addr  in  ADDR_WIDTH  frame start address; sampled when start is accepted.
- busy  out  1  high from start acceptance until the done pulse, inclusive.
- done  out  1  one-cycle pulse after the final transfer.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_rd_data  in  DATA_WIDTH  RAM data; valid exactly 1 cycle after mem_rd_en.
- input_valid  out  1  data_out holds a pixel.
- data_out  out  DATA_WIDTH  pixel to the conv11 input stage.
- data_last  out  1  high together with the final pixel of the frame.
- input_ready  in  1  receiver can accept; a transfer occurs when input_valid && input_ready.

Behaviour:
- Reset: all outputs 0 (busy, done, mem_rd_en, mem_addr, input_valid, data_out, data_last). FSM goes to IDLE, counters clear, the prefetch FIFO empties. Reset mid-frame aborts the frame with no done pulse, and any in-flight read data is discarded.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 → latch base_addr, clear issue_cnt and send_cnt, go to RUN.
  - RUN: stay until send_cnt reaches TOTAL, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- Read issue:
  - mem_rd_en=1 in RUN when issue_cnt<TOTAL and (fifo_count + inflight − pop) < 2.
  - pop = input_valid && input_ready in the same cycle.
  - mem_addr = latched base + issue_cnt. Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - issue_cnt increments on each issued read. inflight is a 1-bit flag equal to the previous cycle's mem_rd_en.
- Prefetch FIFO:
  - 2 entries, written when inflight=1, using mem_rd_data.
  - input_valid = FIFO not empty; data_out = FIFO head.
  - Credit rule guarantees no overflow. Push and pop in the same cycle is legal, and count is unchanged.
- Latency and throughput:
  - Start accepted at edge k. First mem_rd_en in cycle k+1, data written at the end of k+2, input_valid high in cycle k+3.
  - With input_ready held high: one transfer per cycle thereafter, with no bubbles.
- Hold rule: while input_valid=1 and input_ready=0, data_out and data_last stay stable and input_valid stays high. Reads stall once 2 credits are used.
- data_last = input_valid && (send_cnt == TOTAL−1). send_cnt increments on each transfer.
- busy = (state != IDLE).
- Counters are wide enough to hold TOTAL.
- TOTAL=1: single read, single transfer with data_last=1, then done.
- input_ready high while input_valid=0 has no effect.
- No reads are issued after issue_cnt reaches TOTAL. The RAM is never read past base+TOTAL−1.

Test Plan:
- Reset/idle: rst for 3 cycles → all outputs 0. Hold start=0 for 10 cycles → mem_rd_en never asserts.
- Streaming, ready always 1, IMG_W=IMG_H=2, CH=1, base_addr=0x010, RAM[0x010..0x013]=A1,B2,C3,D4:
  - first input_valid in cycle start+3;
  - A1,B2,C3,D4 transfer on 4 consecutive cycles, data_last only on D4;
  - done pulses 1 cycle after D4; busy drops with it.
- Backpressure, same frame: input_ready low for 5 cycles after the first valid:
  - data_out holds A1;
  - exactly 2 reads are outstanding or buffered, then mem_rd_en stays 0;
  - on release, order A1..D4 is preserved with no loss or duplication.
- Random ready: 30%-duty random input_ready, 8x8x2 frame (128 pixels) → scoreboard matches RAM order, exactly 128 transfers, mem_rd_en count is 128.
- Start while busy: start pulse mid-frame → ignored, frame completes normally. Start in the cycle after done → new frame begins.
- Mid-frame reset: rst after 3 transfers → outputs 0 next cycle, no done pulse. A new start then restarts from base_addr, pixel 0.
- Address wrap: base_addr=0xFFE, 4-pixel frame → reads 0xFFE, 0xFFF, 0x000, 0x001.
